// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
// Types: operation codes, FSM states, default data-region geometry.
package mips_lsu_pkg;

    localparam logic [31:0] LSU_DATA_BASE_DEFAULT  = 32'h0000_1000;
    localparam int unsigned LSU_DATA_WORDS_DEFAULT = 64;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        SB  = 4'd5,
        SH  = 4'd6,
        SW  = 4'd7,
        LWL = 4'd8,
        LWR = 4'd9,
        SWL = 4'd10,
        SWR = 4'd11
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_READ,
        WRITE,
        DONE
    } lsu_state_t;

    function automatic logic lsu_op_valid(lsu_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, SB, SH, SW, LWL, LWR, SWL, SWR};
    endfunction

    function automatic logic lsu_is_load(lsu_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    // Sub-word stores need the old word before the full-word write.
    function automatic logic lsu_is_rmw(lsu_op_t op);
        return op inside {SB, SH, SWL, SWR};
    endfunction

    function automatic logic lsu_is_unaligned_op(lsu_op_t op);
        return op inside {LWL, LWR, SWL, SWR};
    endfunction

    // Halfword ops need an even address, word ops a multiple of four.
    function automatic logic lsu_misaligned(lsu_op_t op, logic [1:0] offset);
        case (op)
            LH, LHU, SH: return offset[0];
            LW, SW:      return |offset;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic for the load/store unit (big-endian: offset 0 is
// bits [31:24]). Load path extracts/extends or merges into rt; store path
// replaces the target lanes of the old word.
// LWL/LWR/SWL/SWR merge logic exists only when MIPS_LSU_UNALIGNED_EN is defined.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    // Right shift that brings the addressed byte / halfword down to bit 0.
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_word;
    logic [31:0] half_word;

    assign byte_sh   = {~offset, 3'b000};
    assign half_sh   = {~offset[1], 4'b0000};
    assign byte_word = rdata >> byte_sh;
    assign half_word = rdata >> half_sh;

`ifdef MIPS_LSU_UNALIGNED_EN
    // Left shift that moves the addressed byte up to the most significant lane.
    logic [4:0] lane_sh;
    assign lane_sh = {offset, 3'b000};
`else
    logic unused_merge;
    assign unused_merge = ^rt;
`endif

    // Load result: extract and extend, or merge memory bytes into rt.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data = '0;
        case (op)
            LB:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
            LBU: load_data = {24'h0, byte_word[7:0]};
            LH:  load_data = {{16{half_word[15]}}, half_word[15:0]};
            LHU: load_data = {16'h0, half_word[15:0]};
            LW:  load_data = rdata;
`ifdef MIPS_LSU_UNALIGNED_EN
            LWL: load_data = (rdata << lane_sh) | (rt & ~(32'hFFFF_FFFF << lane_sh));
            LWR: load_data = (rdata >> byte_sh) | (rt & ~(32'hFFFF_FFFF >> byte_sh));
`endif
            default: load_data = '0;
        endcase
    end

    // Store word: old word with the target lanes replaced by store data.
    always_comb begin
        store_data = rdata;
        case (op)
            SB: store_data = (rdata & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wdata[7:0]} << byte_sh);
            SH: store_data = (rdata & ~(32'h0000_FFFF << half_sh)) | ({16'h0, wdata[15:0]} << half_sh);
            SW: store_data = wdata;
`ifdef MIPS_LSU_UNALIGNED_EN
            SWL: store_data = (rdata & ~(32'hFFFF_FFFF >> lane_sh)) | (wdata >> lane_sh);
            SWR: store_data = (rdata & ~(32'hFFFF_FFFF << byte_sh)) | (wdata << byte_sh);
`endif
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the MIPS memory stage and a word-only data memory.
// One request at a time; sub-word stores are done as read-modify-write.
// Optional: MIPS_LSU_UNALIGNED_EN enables LWL/LWR/SWL/SWR; otherwise they
// complete immediately with addr_err.
module mips_cpu_lsu
    import mips_lsu_pkg::*;
#(
    parameter logic [31:0] DATA_BASE  = LSU_DATA_BASE_DEFAULT,
    parameter int unsigned DATA_WORDS = LSU_DATA_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  lsu_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    lsu_state_t  state;
    lsu_op_t     op_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] rt_q;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // 33-bit end address so a region touching the top of memory cannot wrap.
    logic [32:0] region_end;
    logic        in_range;
    logic        req_err;

    assign region_end = {1'b0, DATA_BASE} + {DATA_WORDS[30:0], 2'b00};
    assign in_range   = (req_addr >= DATA_BASE) && ({1'b0, req_addr} < region_end);

    // Error classification of the presented request, used only at accept.
    always_comb begin
        req_err = !in_range || !lsu_op_valid(req_op) || lsu_misaligned(req_op, req_addr[1:0]);
`ifndef MIPS_LSU_UNALIGNED_EN
        if (lsu_is_unaligned_op(req_op)) req_err = 1'b1;
`endif
    end

    mips_lsu_align u_align (
        .op         (op_q),
        .offset     (offset_q),
        .rdata      (data_readdata),
        .rt         (rt_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Request FSM with registered strobes and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            addr_err       <= 1'b0;
            data_read      <= 1'b0;
            data_write     <= 1'b0;
            data_address   <= '0;
            data_writedata <= '0;
            op_q           <= LB;
            offset_q       <= '0;
            wdata_q        <= '0;
            rt_q           <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q         <= req_op;
                        offset_q     <= req_addr[1:0];
                        wdata_q      <= req_wdata;
                        rt_q         <= req_rt;
                        data_address <= {req_addr[31:2], 2'b00};
                        req_ready    <= 1'b0;
                        if (req_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            addr_err   <= 1'b1;
                        end else if (lsu_is_load(req_op)) begin
                            state     <= READ;
                            data_read <= 1'b1;
                        end else if (lsu_is_rmw(req_op)) begin
                            state     <= RMW_READ;
                            data_read <= 1'b1;
                        end else begin
                            state          <= WRITE;
                            data_write     <= 1'b1;
                            data_writedata <= req_wdata;
                        end
                    end
                end
                READ: begin
                    data_read  <= 1'b0;
                    resp_rdata <= load_data;
                    addr_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                RMW_READ: begin
                    data_read      <= 1'b0;
                    data_write     <= 1'b1;
                    data_writedata <= store_data;
                    state          <= WRITE;
                end
                WRITE: begin
                    data_write <= 1'b0;
                    resp_rdata <= '0;
                    addr_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    data_read  <= 1'b0;
                    data_write <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_cpu_lsu.md
# mips_cpu_lsu

Load/store unit between the MIPS core's memory stage and the data-memory port (`data_address`/`data_read`/`data_write`/`data_writedata`/`data_readdata`). The unit handles byte-lane extraction, sign/zero extension and alignment checks. The data memory only performs whole-word writes, so the unit emulates sub-word stores with a read-modify-write sequence. It accepts one request at a time from the core and returns one response per request.

## Interface
Parameters:
- `DATA_BASE`, 32'h00001000, base of data region; only used for the `addr_err` range check.
- `DATA_WORDS`, 64, data region size in words; accesses outside `[DATA_BASE, DATA_BASE+4*DATA_WORDS)` set `addr_err`.

Ports:
- `clk`  in  1  single clock, posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept a request (IDLE only).
- `req_op`  in  4  `lsu_op_t`: LB, LBU, LH, LHU, LW, SB, SH, SW, LWL, LWR, SWL, SWR.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (low bytes used for SB/SH).
- `req_rt`  in  32  old rt value; merge source for LWL/LWR.
- `resp_valid`  out  1  one-cycle pulse; response fields valid.
- `resp_rdata`  out  32  load result; 0 for stores.
- `addr_err`  out  1  qualifies `resp_valid`; misaligned, out of range, or disabled op.
- `data_address`  out  32  word-aligned, `{req_addr[31:2],2'b00}`.
- `data_read`  out  1  memory read strobe.
- `data_write`  out  1  memory write strobe.
- `data_writedata`  out  32  merged write word.
- `data_readdata`  in  32  combinational read data, valid in the same cycle as `data_read`.

## Operation
- Byte order is big-endian: offset 0 maps to bits [31:24].
- FSM states: IDLE, READ, RMW_READ, WRITE, DONE. Request is accepted on an edge where `req_valid && req_ready`; address, op and data are registered.
- From IDLE on accept:
  - Error case goes to DONE. No memory strobe is ever asserted.
  - LB/LBU/LH/LHU/LW/LWL/LWR go to READ.
  - SW goes to WRITE.
  - SB/SH/SWL/SWR go to RMW_READ.
- READ: `data_read`=1. Extended or merged result is captured into `resp_rdata` at the edge. Next state DONE.
- RMW_READ: `data_read`=1. `data_readdata` is captured. Next state WRITE.
- WRITE: `data_write`=1. `data_writedata` is the captured word with the target lanes replaced (SW: `req_wdata`). Next state DONE.
- DONE: `resp_valid`=1 for exactly one cycle, with `addr_err` as determined at accept. Next state IDLE.
- Alignment rules:
  - LH/LHU/SH need `addr[0]`=0.
  - LW/SW need `addr[1:0]`=0.
  - Byte and LWL/LWR/SWL/SWR ops are never misaligned.
- `data_read` and `data_write` are never both high.
- `resp_rdata` and `addr_err` hold their values until the next DONE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `addr_err`=0, `data_read`=0, `data_write`=0, `data_address`=0, `data_writedata`=0.
- Latency from accept edge to `resp_valid`:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - RMW store: 3 cycles.
- `req_ready`=0 in every non-IDLE state. A held `req_valid` is accepted on the edge leaving DONE→IDLE+1; no request is dropped or duplicated.
- Reset asserted mid-operation forces IDLE and drops strobes combinationally. A WRITE cut by reset before its edge performs no memory write. No response is emitted for the aborted request.

## Configuration
- `MIPS_LSU_UNALIGNED_EN`:
  - Defined: LWL/LWR/SWL/SWR are implemented with standard big-endian MIPS merge semantics.
  - Undefined: these four ops go straight to DONE with `addr_err`=1, and the merge logic is not compiled.

## Structure
- `mips_lsu_pkg` holds:
  - `lsu_op_t` (4-bit enum).
  - `lsu_state_t`.
  - Constants `LSU_DATA_BASE_DEFAULT` and `LSU_DATA_WORDS_DEFAULT`.
- Sub-module `mips_lsu_align`, purely combinational:
  - Load extract/extend/merge: op, offset, read word, rt → result.
  - Store merge: op, offset, old word, wdata → write word.
  - The FSM in `mips_cpu_lsu` instantiates it once.

## Test plan
- Word 0x1000 = 0x8122F344:
  - LB 0x1000 → 0xFFFFFF81.
  - LBU 0x1000 → 0x00000081.
  - LH 0x1002 → 0xFFFFF344.
  - LW 0x1000 → 0x8122F344.
  - Each case: `resp_valid` 2 cycles after accept.
- Word 0x1004 = 0x11223344:
  - Sequence: SB addr 0x1007, wdata 0x000000AB.
  - Expected: `data_read` in cycle 1, `data_write` in cycle 2 with 0x112233AB, response in cycle 3.
  - Memory then reads 0x112233AB.
- LW 0x1002 or SH 0x1001 → `addr_err`=1 after 1 cycle; `data_read`/`data_write` never asserted; memory unchanged.
- SW 0x1008, data 0xDEADBEEF, with `rst_n` dropped during WRITE before the edge:
  - Strobes fall immediately and word 0x1008 is unchanged.
  - No `resp_valid`; `req_ready`=1 after reset release.
- `req_valid` held high across two LW requests → `req_ready` low while busy, exactly two `resp_valid` pulses, second request accepted only from IDLE.
- Word 0x1004 = 0x11223344:
  - With `MIPS_LSU_UNALIGNED_EN`: LWL 0x1005, rt 0xAABBCCDD → 0x223344DD.
  - Without the macro: same request → `addr_err`=1 and no memory access.
